// File: rtl/tick_scheduler.sv
// Per-channel programmable tick dividers off the 1 ms clock, with expiries merged
// into pending bits and delivered one at a time through a round-robin valid/ready port.
module tick_scheduler #(
  parameter int NCH            = 4,
  parameter int PW             = 8,
  parameter int DEFAULT_PERIOD = 5,
  parameter int IW             = 2
) (
  input  logic           clk_1ms,
  input  logic           reset,
  input  logic           pause,
  input  logic [NCH-1:0] ch_en,
  input  logic           cfg_wr,
  input  logic [IW-1:0]  cfg_sel,
  input  logic [PW-1:0]  cfg_period,
  output logic           cfg_ack,
  output logic           evt_valid,
  output logic [IW-1:0]  evt_id,
  input  logic           evt_ready,
  output logic [NCH-1:0] evt_overrun
);

  // state   | meaning
  // S_IDLE  | nothing offered; grant on the next edge if any channel is pending
  // S_OFFER | evt_id held on the port until the consumer takes it
  typedef enum logic {S_IDLE, S_OFFER} state_t;

  state_t         state, next_state;
  logic [PW-1:0]  cnt [NCH];
  logic [PW-1:0]  per [NCH];
  logic [NCH-1:0] pending;
  logic [NCH-1:0] count_en;
  logic [NCH-1:0] expire;
  logic [NCH-1:0] cfg_hit;
  logic [NCH-1:0] grant_mask;
  logic [IW-1:0]  last_grant;
  logic [IW-1:0]  search_base;
  logic [IW-1:0]  winner;
  logic           found;
  logic           issue;
  logic           handshake;

  always_comb begin
    count_en = '0;
    expire   = '0;
    cfg_hit  = '0;
    for (int i = 0; i < NCH; i++) begin
      count_en[i] = ch_en[i] && !pause && (per[i] != '0);
      expire[i]   = count_en[i] && (cnt[i] == per[i] - PW'(1));
      cfg_hit[i]  = cfg_wr && (cfg_sel == IW'(i));
    end
  end

  // After a handshake the offered id becomes last_grant on this edge, so search from it.
  always_comb begin
    int idx;
    search_base = (state == S_OFFER) ? evt_id : last_grant;
    winner      = '0;
    found       = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(search_base) + k) % NCH;
      if (!found && pending[idx]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    issue      = 1'b0;
    handshake  = 1'b0;
    case (state)
      S_IDLE: begin
        if (|pending) begin
          issue      = 1'b1;
          next_state = S_OFFER;
        end
      end
      S_OFFER: begin
        if (evt_ready) begin
          handshake = 1'b1;
          if (|pending) issue = 1'b1;
          else next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
    grant_mask = '0;
    if (issue) grant_mask[winner] = 1'b1;
  end

  always_ff @(posedge clk_1ms or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      last_grant <= IW'(NCH - 1);
      cfg_ack    <= 1'b0;
    end else begin
      state     <= next_state;
      evt_valid <= (next_state == S_OFFER);
      cfg_ack   <= cfg_wr;
      if (issue) evt_id <= winner;
      if (handshake) last_grant <= evt_id;
    end
  end

  // A tick granted on the same edge it re-expires has been delivered, so it is not an overrun.
  always_ff @(posedge clk_1ms or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
        per[i] <= PW'(DEFAULT_PERIOD);
      end
      pending     <= '0;
      evt_overrun <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cfg_hit[i]) begin
          per[i]         <= cfg_period;
          cnt[i]         <= '0;
          pending[i]     <= 1'b0;
          evt_overrun[i] <= 1'b0;
        end else if (!ch_en[i]) begin
          cnt[i]     <= '0;
          pending[i] <= 1'b0;
        end else begin
          if (count_en[i]) cnt[i] <= expire[i] ? '0 : cnt[i] + PW'(1);
          if (expire[i]) begin
            if (pending[i] && !grant_mask[i]) evt_overrun[i] <= 1'b1;
            pending[i] <= 1'b1;
          end else if (grant_mask[i]) begin
            pending[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: a per-cycle vector table for steady-state
// schedules plus hand sequences for backpressure, config, pause and mid-cycle reset.
module tb_tick_scheduler;

  logic       clk_1ms = 1'b0;
  logic       reset;
  logic       pause;
  logic [3:0] ch_en;
  logic       cfg_wr;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_period;
  logic       cfg_ack;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_ready;
  logic [3:0] evt_overrun;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0] ch_en;
    logic       ready;
    logic       exp_valid;
    logic [1:0] exp_id;
    logic [3:0] exp_ovr;
  } vec_t;

  vec_t tbl[$];

  tick_scheduler #(.NCH(4), .PW(8), .DEFAULT_PERIOD(5), .IW(2)) dut (
    .clk_1ms(clk_1ms), .reset(reset), .pause(pause), .ch_en(ch_en),
    .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_period(cfg_period), .cfg_ack(cfg_ack),
    .evt_valid(evt_valid), .evt_id(evt_id), .evt_ready(evt_ready),
    .evt_overrun(evt_overrun)
  );

  always #5 clk_1ms = ~clk_1ms;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_1ms);
    #1;
  endtask

  // Leaves the bench 3 time units after an edge with reset released.
  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic run_vec(input int lo, input int hi);
    for (int v = lo; v <= hi; v++) begin
      ch_en     = tbl[v].ch_en;
      evt_ready = tbl[v].ready;
      tick();
      check($sformatf("vec%0d valid", v), evt_valid, tbl[v].exp_valid);
      if (tbl[v].exp_valid) check($sformatf("vec%0d id", v), evt_id, tbl[v].exp_id);
      check($sformatf("vec%0d overrun", v), evt_overrun, tbl[v].exp_ovr);
    end
  endtask

  initial begin
    // single channel, default period: pulse at edges 6, 11, 16
    for (int k = 1; k <= 16; k++)
      tbl.push_back('{4'b0001, 1'b1, (k == 6 || k == 11 || k == 16), 2'd0, 4'b0000});
    // four channels, default period: ids 0..3 back to back, then a one-cycle gap
    for (int k = 1; k <= 15; k++) begin
      logic v;
      logic [1:0] id;
      v  = (k >= 6 && k <= 9) || (k >= 11 && k <= 14);
      id = (k <= 9) ? 2'(k - 6) : 2'(k - 11);
      tbl.push_back('{4'b1111, 1'b1, v, v ? id : 2'd0, 4'b0000});
    end

    reset = 1'b1; pause = 1'b0; ch_en = '0; cfg_wr = 1'b0;
    cfg_sel = '0; cfg_period = '0; evt_ready = 1'b1;
    #2;
    check("reset valid", evt_valid, 1'b0);
    check("reset id", evt_id, 2'd0);
    check("reset ack", cfg_ack, 1'b0);
    check("reset overrun", evt_overrun, 4'b0000);
    #5;
    reset = 1'b0;

    run_vec(0, 15);
    pulse_reset();
    run_vec(16, 30);

    // backpressure with ch0 at period 2: held offer, overrun, one merged event left
    pulse_reset();
    ch_en = 4'b0001; evt_ready = 1'b0;
    cfg_wr = 1'b1; cfg_sel = 2'd0; cfg_period = 8'd2;
    tick();
    cfg_wr = 1'b0;
    check("bp ack g1", cfg_ack, 1'b1);
    for (int k = 2; k <= 10; k++) begin
      tick();
      if (k == 2) check("bp ack g2", cfg_ack, 1'b0);
      check($sformatf("bp valid g%0d", k), evt_valid, k >= 4);
      if (k >= 4) check($sformatf("bp id g%0d", k), evt_id, 2'd0);
      check($sformatf("bp ovr g%0d", k), evt_overrun, (k >= 7) ? 4'b0001 : 4'b0000);
    end
    evt_ready = 1'b1; pause = 1'b1;
    tick();
    check("bp merged valid", evt_valid, 1'b1);
    check("bp merged id", evt_id, 2'd0);
    tick();
    check("bp drained g12", evt_valid, 1'b0);
    tick();
    check("bp drained g13", evt_valid, 1'b0);
    check("bp ovr sticky", evt_overrun, 4'b0001);
    pause = 1'b0;

    // config write restarts ch2 at period 3, then period 0 silences it
    pulse_reset();
    ch_en = 4'b0100; evt_ready = 1'b1;
    for (int k = 1; k <= 3; k++) tick();
    check("cfg pre valid", evt_valid, 1'b0);
    cfg_wr = 1'b1; cfg_sel = 2'd2; cfg_period = 8'd3;
    tick();
    cfg_wr = 1'b0;
    check("cfg ack h4", cfg_ack, 1'b1);
    for (int k = 5; k <= 14; k++) begin
      tick();
      if (k == 5) check("cfg ack h5", cfg_ack, 1'b0);
      check($sformatf("cfg valid h%0d", k), evt_valid, (k == 8 || k == 11 || k == 14));
      if (k == 8) check("cfg id h8", evt_id, 2'd2);
    end
    cfg_wr = 1'b1; cfg_period = 8'd0;
    tick();
    cfg_wr = 1'b0;
    check("cfg0 ack", cfg_ack, 1'b1);
    for (int k = 16; k <= 22; k++) begin
      tick();
      check($sformatf("cfg0 valid h%0d", k), evt_valid, 1'b0);
    end

    // pause with cnt[1]=2: expiry three counting cycles after release
    pulse_reset();
    ch_en = 4'b0010;
    tick(); tick();
    pause = 1'b1;
    for (int k = 3; k <= 12; k++) begin
      if (k == 10) pause = 1'b0;
      tick();
      check($sformatf("pause valid j%0d", k), evt_valid, 1'b0);
    end
    tick();
    check("pause valid j13", evt_valid, 1'b1);
    check("pause id j13", evt_id, 2'd1);

    // asynchronous reset while an event is offered and others pending
    pulse_reset();
    ch_en = 4'b1111; evt_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 6) check("ar offer id", evt_id, 2'd0);
    end
    check("ar pre valid", evt_valid, 1'b1);
    check("ar pre ovr", evt_overrun, 4'b1110);
    reset = 1'b1;
    #1;
    check("ar async valid", evt_valid, 1'b0);
    check("ar async ovr", evt_overrun, 4'b0000);
    #1;
    reset = 1'b0;
    ch_en = 4'b0110; evt_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("ar valid l%0d", k), evt_valid, (k == 6 || k == 7));
      if (k == 6) check("ar first id", evt_id, 2'd1);
      if (k == 7) check("ar second id", evt_id, 2'd2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
